// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file with a per-register pending-write
// scoreboard.
//
// Holds NREGS x XLEN registers (x0 hardwired to zero) written by the
// writeback stage. Decode reads them through two combinational ports. Each
// register r != 0 also has a CNTW-bit pending counter. Decode increments it
// when it issues an instruction that writes r, and a writeback to r
// decrements it. The busy flags let decode stall on RAW hazards.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   i_wr_addr/data/en       writeback write port (also retires pending writes)
//   i_rs1_addr, i_rs2_addr  read port addresses
//   o_rs1_data, o_rs2_data  read port data (combinational)
//   o_rs1_busy, o_rs2_busy  source has an outstanding write not yet visible
//   i_issue_en, i_issue_rd  decode issues an instruction writing i_issue_rd
//   o_sb_full               counter of i_issue_rd is saturated; hold issue
//   o_sb_err                sticky: issue while full, or retire with count 0
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// to the read ports. In that case busy ignores the write being retired.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNTW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_issue_en,
    input  logic [AW-1:0]   i_issue_rd,
    output logic            o_sb_full,
    output logic            o_sb_err
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CNTW-1:0] cnt_q  [NREGS];
    logic [CNTW-1:0] cnt_d  [NREGS];
    logic            err_q;
    logic            err_d;
    logic            full;
    logic            inc;
    logic            dec;

    always_comb begin
        full = (i_issue_rd != '0) && (cnt_q[i_issue_rd] == '1);
    end

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        inc    = 1'b0;
        dec    = 1'b0;

        if (i_issue_en && full) begin
            err_d = 1'b1;
        end

        if (i_wr_en && (i_wr_addr != '0)) begin
            regs_d[i_wr_addr] = i_wr_data;
        end

        // x0 has no counter activity; start at 1.
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc = i_issue_en && (i_issue_rd == AW'(r)) && !full;
            dec = i_wr_en && (i_wr_addr == AW'(r));
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        o_rs1_data = (i_rs1_addr == '0) ? '0 : regs_q[i_rs1_addr];
        o_rs1_busy = (i_rs1_addr != '0) && (cnt_q[i_rs1_addr] != '0);
`ifdef REGFILE_BYPASS_EN
        // The write retiring this cycle is forwarded, so only writes still
        // behind it keep the source busy.
        if (i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rs1_addr)) begin
            o_rs1_data = i_wr_data;
            o_rs1_busy = cnt_q[i_rs1_addr] > CNTW'(1);
        end
`endif
    end

    always_comb begin
        o_rs2_data = (i_rs2_addr == '0) ? '0 : regs_q[i_rs2_addr];
        o_rs2_busy = (i_rs2_addr != '0) && (cnt_q[i_rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
        if (i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rs2_addr)) begin
            o_rs2_data = i_wr_data;
            o_rs2_busy = cnt_q[i_rs2_addr] > CNTW'(1);
        end
`endif
    end

    assign o_sb_full = full;
    assign o_sb_err  = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- self-checking bench for regfile_sb.
// Stimulus drives one vector per cycle just after the rising edge and queues
// the hand-computed response. A monitor on the falling edge pops and compares.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_wr_en = 1'b0;
    logic [4:0]  i_rs1_addr = '0;
    logic [4:0]  i_rs2_addr = '0;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic        i_issue_en = 1'b0;
    logic [4:0]  i_issue_rd = '0;
    logic        o_sb_full;
    logic        o_sb_err;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic        full;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id = 0;
    bit   stim_done = 1'b0;

    regfile_sb #(
        .XLEN (32),
        .NREGS(32),
        .AW   (5),
        .CNTW (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_wr_en   (i_wr_en),
        .i_rs1_addr(i_rs1_addr),
        .i_rs2_addr(i_rs2_addr),
        .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data),
        .o_rs1_busy(o_rs1_busy),
        .o_rs2_busy(o_rs2_busy),
        .i_issue_en(i_issue_en),
        .i_issue_rd(i_issue_rd),
        .o_sb_full (o_sb_full),
        .o_sb_err  (o_sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
        end
    endtask

    // One cycle of stimulus; when chk is set the response expected while
    // these inputs are held is queued for the monitor.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic ie, input logic [4:0] ir,
                        input bit chk, input logic [31:0] e1d, input logic e1b,
                        input logic [31:0] e2d, input logic e2b, input logic ef,
                        input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rst;
        i_wr_en    = we;
        i_wr_addr  = wa;
        i_wr_data  = wd;
        i_rs1_addr = r1;
        i_rs2_addr = r2;
        i_issue_en = ie;
        i_issue_rd = ir;
        vec_id++;
        if (chk) begin
            e.id = vec_id; e.d1 = e1d; e.b1 = e1b; e.d2 = e2d; e.b2 = e2b;
            e.full = ef; e.err = ee;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_data", e.id, o_rs1_data, e.d1);
            check("rs1_busy", e.id, 32'(o_rs1_busy), 32'(e.b1));
            check("rs2_data", e.id, o_rs2_data, e.d2);
            check("rs2_busy", e.id, 32'(o_rs2_busy), 32'(e.b2));
            check("sb_full", e.id, 32'(o_sb_full), 32'(e.full));
            check("sb_err", e.id, 32'(o_sb_err), 32'(e.err));
        end
    end

    initial begin
        // Reset edge, then read x1/x31.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 31, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Issue x5, then retire it with 0xDEADBEEF.
        step(1, 0, 0, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 1,
             BYP ? 32'hDEADBEEF : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        // Write and issue to x0 are ignored.
        step(1, 1, 0, 32'h1234, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        // Two issues to x7, two retires.
        step(1, 0, 0, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 0, 1, 7, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 7, 32'h77, 7, 0, 0, 7, 1, BYP ? 32'h77 : 32'h0, 1, 0, 0, 0, 0);
        step(1, 1, 7, 32'h777, 7, 0, 0, 7, 1,
             BYP ? 32'h777 : 32'h77, BYP ? 1'b0 : 1'b1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 0, 0, 0, 1, 32'h777, 0, 0, 0, 0, 0);
        // Same-cycle issue and retire on x3 with count 1.
        step(1, 0, 0, 0, 3, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h33, 3, 0, 1, 3, 1,
             BYP ? 32'h33 : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3, 0, 0, 0, 1, 32'h33, 1, 0, 0, 0, 0);
        // Saturate x9, illegal fourth issue, three retires.
        step(1, 0, 0, 0, 9, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 9, 0, 1, 9, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 9, 0, 1, 9, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 9, 0, 1, 9, 1, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 9, 0, 0, 9, 1, 0, 1, 0, 0, 1, 1);
        step(1, 1, 9, 32'h99, 9, 0, 0, 9, 1, BYP ? 32'h99 : 32'h0, 1, 0, 0, 1, 1);
        step(1, 1, 9, 32'h999, 9, 0, 0, 9, 1, BYP ? 32'h999 : 32'h99, 1, 0, 0, 0, 1);
        step(1, 1, 9, 32'h9999, 9, 0, 0, 9, 1,
             BYP ? 32'h9999 : 32'h999, BYP ? 1'b0 : 1'b1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 9, 0, 0, 9, 1, 32'h9999, 0, 0, 0, 0, 1);
        // Reset clears data, pending x3 count and the sticky error.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 9, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Retire x12 with count 0: written, error, no underflow.
        step(1, 1, 12, 32'hC0FFEE, 12, 12, 0, 12, 1,
             BYP ? 32'hC0FFEE : 32'h0, 0, BYP ? 32'hC0FFEE : 32'h0, 0, 0, 0);
        step(1, 0, 0, 0, 12, 12, 0, 12, 1, 32'hC0FFEE, 0, 32'hC0FFEE, 0, 0, 1);
        step(1, 0, 0, 0, 12, 0, 1, 12, 1, 32'hC0FFEE, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 12, 0, 0, 12, 1, 32'hC0FFEE, 1, 0, 0, 0, 1);
        // Reset with pending x12, overriding same-cycle issue and write.
        step(0, 1, 12, 32'hAA, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 12, 20, 0, 20, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 20, 12, 0, 12, 1, 0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin
        int waited;
        waited = 0;
        while (!stim_done && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (!stim_done || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: stim_done=%0d pending=%0d expected done=1 pending=0",
                     stim_done, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file that receives the writeback stage's write port (address, data, enable). Serves two combinational read ports to the decode stage.
- Contains a per-register pending-write scoreboard. Decode marks a destination busy at issue; writeback retires it.
- Decode uses the busy flags to stall on RAW hazards.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (x0..x(NREGS-1))
AW, 5, register address width, $clog2(NREGS)
CNTW, 2, width of each scoreboard pending counter (max in-flight writes per register = 2^CNTW-1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
i_wr_addr  input  AW  writeback destination register
i_wr_data  input  XLEN  writeback data
i_wr_en  input  1  writeback write enable
i_rs1_addr  input  AW  read port 1 address
i_rs2_addr  input  AW  read port 2 address
o_rs1_data  output  XLEN  read port 1 data
o_rs2_data  output  XLEN  read port 2 data
o_rs1_busy  output  1  rs1 has an outstanding write not yet visible on o_rs1_data
o_rs2_busy  output  1  same for rs2
i_issue_en  input  1  decode issues an instruction that will write i_issue_rd
i_issue_rd  input  AW  destination of issued instruction
o_sb_full  output  1  counter of i_issue_rd is at max; issue must be held
o_sb_err  output  1  sticky: illegal issue at max, or retire with counter 0

Behaviour:
- Storage: NREGS x XLEN array plus NREGS x CNTW pending counters. All state changes on posedge clk.
- Reset: while rst_n=0 at a clk edge:
  - all registers cleared to 0; all counters cleared to 0; o_sb_err cleared to 0.
  - Reset overrides any write, issue or retire in the same cycle.
  - Reset mid-operation discards all in-flight scoreboard state.
- Write: if i_wr_en=1 and i_wr_addr!=0, reg[i_wr_addr] <= i_wr_data at the edge.
  - Writes to x0 are ignored.
  - x0 always reads 0 and is never busy.
- Reads are combinational; zero latency from address to data. Base value: reg[addr], or 0 for addr 0.
- Scoreboard, per register r != 0:
  - inc = i_issue_en && i_issue_rd==r && !o_sb_full; dec = i_wr_en && i_wr_addr==r.
  - inc only -> cnt+1. dec only -> cnt-1. Both, or neither -> unchanged.
  - Issue to x0 or wr_en to x0 never changes any counter.
- o_sb_full = i_issue_rd!=0 && cnt[i_issue_rd]==2^CNTW-1. It is combinational.
- Issue with i_issue_en=1 while o_sb_full=1:
  - the counter holds (saturates) and o_sb_err is set.
  - Decode must not do this.
- Retire (i_wr_en=1, addr!=0) with cnt==0 and no same-cycle issue to that register:
  - counter stays 0 (no underflow) and o_sb_err is set.
  - The write to the array still occurs.
- o_sb_err is sticky until reset.
- Busy, combinational: o_rsN_busy = addr!=0 && cnt[addr]!=0, subject to the optional bypass adjustment below.
- Both read ports may address the same register; the outputs are then identical.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - if i_wr_en=1, i_wr_addr!=0 and i_wr_addr==i_rsN_addr, then o_rsN_data = i_wr_data (write-through, same cycle).
  - In that case o_rsN_busy = (cnt[addr] > 1).
  - Decode can issue in the same cycle writeback retires the last pending write.
- Not defined:
  - reads always return the array value; new data is visible the cycle after the write edge.
  - o_rsN_busy = cnt[addr]!=0, so busy drops the cycle after retire.
- Scoreboard counting is identical in both builds.

Test Plan:
- Reset then reads: hold rst_n=0 one edge, release; read x1, x31 -> data 0, busy 0, o_sb_err 0.
- Write x5=0xDEADBEEF, next cycle read rs1=5, rs2=0 -> o_rs1_data=0xDEADBEEF, o_rs2_data=0. Write x0=0x1234 -> x0 still reads 0.
- Issue rd=7 twice on consecutive cycles, expect busy on rs1=7.
  - Retire once -> still busy.
  - Retire again -> with REGFILE_BYPASS_EN, busy=0 and data=wr_data in the retire cycle; without it, busy=0 and new data the next cycle.
- Same-cycle issue rd=3 and retire x3 with cnt=1 -> counter stays 1, busy stays 1, reg[3] updated.
- Issue rd=9 three times (CNTW=2) -> o_sb_full=1 while i_issue_rd=9. A fourth issue -> cnt stays 3, o_sb_err=1. o_sb_err stays set after three retires until rst_n=0.
- Retire x12 with cnt=0 -> o_sb_err=1, reg[12] written, cnt 0. Assert rst_n=0 mid-stream with pending counters -> all busy 0, all data 0, err 0 next cycle.
